// File: rtl/tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tracker_pkg
// Description : Shared types and constants for the object bounding-box
//               tracker and the pixel-position counter. Provides the
//               coordinate/count widths, the tracker state encoding, the
//               bounding-box accumulator record and a centre helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tracker_pkg;

    localparam int CW = 10;   // coordinate width (columns / rows)
    localparam int NW = 20;   // foreground pixel count width

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        PUBLISH = 2'd2,
        DONE    = 2'd3
    } trk_state_t;

    typedef struct packed {
        logic [CW-1:0] xmin;
        logic [CW-1:0] xmax;
        logic [CW-1:0] ymin;
        logic [CW-1:0] ymax;
        logic [NW-1:0] cnt;
    } bbox_t;

    // Midpoint of two coordinates: the sum is formed one bit wider so it
    // cannot wrap, then the shift drops back to coordinate width.
    function automatic logic [CW-1:0] centre(input logic [CW-1:0] a,
                                             input logic [CW-1:0] b);
        logic [CW:0] w_sum;
        w_sum = {1'b0, a} + {1'b0, b};
        return w_sum[CW:1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/pix_pos_counter.sv
`default_nettype none
// ============================================================================
// Module      : pix_pos_counter
// Description : Tracks the column/row position of the incoming pixel stream.
//               Detects frame start (rising cap_vsync against a registered
//               copy), line end (falling pix_vld against a registered copy)
//               and frame end (line end of the last active row).
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_cap_vsync      - frame sync
//               i_pix_vld        - pixel valid, one contiguous run per line
//               o_x_cnt/o_y_cnt  - position of the current pixel
//               o_frame_start    - rising edge of cap_vsync (this cycle)
//               o_line_end       - first idle cycle after a pixel run
//               o_frame_end      - line end of row IH-1
//               o_pix_ok         - current pixel lies inside IW x IH
// Revision    : 1.0 - initial release
// ============================================================================
module pix_pos_counter
    import tracker_pkg::*;
#(
    parameter int IW = 800,
    parameter int IH = 600
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cap_vsync,
    input  logic          i_pix_vld,
    output logic [CW-1:0] o_x_cnt,
    output logic [CW-1:0] o_y_cnt,
    output logic          o_frame_start,
    output logic          o_line_end,
    output logic          o_frame_end,
    output logic          o_pix_ok
);

    localparam logic [CW-1:0] c_iw = CW'(IW);
    localparam logic [CW-1:0] c_ih = CW'(IH);

    logic          r_vsync_d;
    logic          r_vld_d;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;

    assign o_frame_start = i_cap_vsync & ~r_vsync_d;
    assign o_line_end    = r_vld_d & ~i_pix_vld;
    assign o_frame_end   = o_line_end && (r_y == c_ih - 1'b1);
    assign o_pix_ok      = i_pix_vld && (r_x < c_iw) && (r_y < c_ih);
    assign o_x_cnt       = r_x;
    assign o_y_cnt       = r_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync_d <= 1'b0;
            r_vld_d   <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_vsync_d <= i_cap_vsync;
            r_vld_d   <= i_pix_vld;
            if (o_frame_start) begin
                r_x <= '0;
                r_y <= '0;
            end else if (o_line_end) begin
                r_x <= '0;
                // Saturate at IH so surplus lines can never wrap back
                // into the active window.
                if (r_y < c_ih)
                    r_y <= r_y + 1'b1;
            end else if (i_pix_vld && (r_x < c_iw)) begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/object_bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module      : object_bbox_tracker
// Description : Thresholds the equalized 8-bit pixel stream into a 1-bit
//               overlay stream and accumulates the bounding box, centre and
//               foreground count of each frame, publishing them once per
//               complete frame with a single-cycle res_vld pulse.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               cap_vsync              - frame sync (rising edge = start)
//               pix_vld, pix_data      - equalized pixel stream
//               thr, thr_inv           - threshold / polarity, latched per frame
//               bin_vld, bin_data      - binarized stream, 1-cycle latency
//               res_vld                - result update strobe
//               obj_found              - pix_cnt >= MIN_PIX
//               x_min/x_max/y_min/y_max- bounding box
//               x_ctr/y_ctr            - box centre
//               pix_cnt                - foreground pixels in the frame
// Revision    : 1.0 - initial release
// ============================================================================
module object_bbox_tracker
    import tracker_pkg::*;
#(
    parameter int IW      = 800,
    parameter int IH      = 600,
    parameter int MIN_PIX = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_vsync,
    input  logic          pix_vld,
    input  logic [7:0]    pix_data,
    input  logic [7:0]    thr,
    input  logic          thr_inv,
    output logic          bin_vld,
    output logic          bin_data,
    output logic          res_vld,
    output logic          obj_found,
    output logic [CW-1:0] x_min,
    output logic [CW-1:0] x_max,
    output logic [CW-1:0] y_min,
    output logic [CW-1:0] y_max,
    output logic [CW-1:0] x_ctr,
    output logic [CW-1:0] y_ctr,
    output logic [NW-1:0] pix_cnt
);

    localparam logic [CW-1:0] c_iw      = CW'(IW);
    localparam logic [CW-1:0] c_ih      = CW'(IH);
    localparam logic [NW-1:0] c_min_pix = NW'(MIN_PIX);

    logic [CW-1:0] w_x;
    logic [CW-1:0] w_y;
    logic          w_frame_start;
    logic          w_line_end;
    logic          w_frame_end;
    logic          w_pix_ok;
    logic          w_fg;
    logic          w_acc_en;
    logic          w_publish;

    trk_state_t    r_state;
    trk_state_t    w_state_nxt;
    bbox_t         r_acc;
    logic [7:0]    r_thr;
    logic          r_thr_inv;

    pix_pos_counter #(
        .IW (IW),
        .IH (IH)
    ) u_pos (
        .clk           (clk),
        .rst           (rst),
        .i_cap_vsync   (cap_vsync),
        .i_pix_vld     (pix_vld),
        .o_x_cnt       (w_x),
        .o_y_cnt       (w_y),
        .o_frame_start (w_frame_start),
        .o_line_end    (w_line_end),
        .o_frame_end   (w_frame_end),
        .o_pix_ok      (w_pix_ok)
    );

    assign w_fg     = r_thr_inv ? (pix_data < r_thr) : (pix_data > r_thr);
    assign w_acc_en = (r_state == ACTIVE) && w_pix_ok && w_fg;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_publish   = 1'b0;
        case (r_state)
            IDLE:    if (w_frame_start) w_state_nxt = ACTIVE;
            ACTIVE: begin
                // A new vsync while still collecting is a short frame:
                // stay in ACTIVE, the accumulators get reloaded below.
                if (w_frame_start)
                    w_state_nxt = ACTIVE;
                else if (w_line_end && w_frame_end)
                    w_state_nxt = PUBLISH;
            end
            PUBLISH: begin
                // The publish copy and a coinciding accumulator reload share
                // one edge; the copy samples the old values, so nothing is
                // lost and the new frame is live from the next cycle.
                w_publish   = 1'b1;
                w_state_nxt = w_frame_start ? ACTIVE : DONE;
            end
            DONE:    if (w_frame_start) w_state_nxt = ACTIVE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------- accumulators
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr     <= '0;
            r_thr_inv <= 1'b0;
            r_acc     <= '0;
        end else if (w_frame_start) begin
            r_thr      <= thr;
            r_thr_inv  <= thr_inv;
            r_acc.xmin <= c_iw - 1'b1;
            r_acc.xmax <= '0;
            r_acc.ymin <= c_ih - 1'b1;
            r_acc.ymax <= '0;
            r_acc.cnt  <= '0;
        end else if (w_acc_en) begin
            if (w_x < r_acc.xmin) r_acc.xmin <= w_x;
            if (w_x > r_acc.xmax) r_acc.xmax <= w_x;
            if (w_y < r_acc.ymin) r_acc.ymin <= w_y;
            if (w_y > r_acc.ymax) r_acc.ymax <= w_y;
            r_acc.cnt <= r_acc.cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------- outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_vld   <= 1'b0;
            bin_data  <= 1'b0;
            res_vld   <= 1'b0;
            obj_found <= 1'b0;
            x_min     <= '0;
            x_max     <= '0;
            y_min     <= '0;
            y_max     <= '0;
            x_ctr     <= '0;
            y_ctr     <= '0;
            pix_cnt   <= '0;
        end else begin
            bin_vld  <= pix_vld;
            bin_data <= pix_vld & w_fg;
            res_vld  <= w_publish;
            if (w_publish) begin
                if (r_acc.cnt == '0) begin
                    // Empty frame: the accumulators still hold their
                    // load values, which must not leak out as a box.
                    obj_found <= 1'b0;
                    x_min     <= '0;
                    x_max     <= '0;
                    y_min     <= '0;
                    y_max     <= '0;
                    x_ctr     <= '0;
                    y_ctr     <= '0;
                    pix_cnt   <= '0;
                end else begin
                    obj_found <= (r_acc.cnt >= c_min_pix);
                    x_min     <= r_acc.xmin;
                    x_max     <= r_acc.xmax;
                    y_min     <= r_acc.ymin;
                    y_max     <= r_acc.ymax;
                    x_ctr     <= centre(r_acc.xmin, r_acc.xmax);
                    y_ctr     <= centre(r_acc.ymin, r_acc.ymax);
                    pix_cnt   <= r_acc.cnt;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_object_bbox_tracker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_object_bbox_tracker
// Description : Self-checking bench for object_bbox_tracker (IW=8, IH=4).
//               A reference model computes each frame's expected result when
//               the frame is driven; a monitor captures every res_vld pulse;
//               each scenario task compares the two queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_object_bbox_tracker;

    localparam int IW = 8;
    localparam int IH = 4;

    typedef struct packed {
        logic [9:0]  xmin;
        logic [9:0]  xmax;
        logic [9:0]  ymin;
        logic [9:0]  ymax;
        logic [9:0]  xc;
        logic [9:0]  yc;
        logic [19:0] cnt;
        logic        found;
        logic        found1;
    } res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cap_vsync = 1'b0;
    logic        pix_vld = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic [7:0]  thr = 8'd0;
    logic        thr_inv = 1'b0;

    logic        bin_vld, bin_data, res_vld, obj_found;
    logic [9:0]  x_min, x_max, y_min, y_max, x_ctr, y_ctr;
    logic [19:0] pix_cnt;
    logic        bin_vld1, bin_data1, res_vld1, obj_found1;
    logic [9:0]  x_min1, x_max1, y_min1, y_max1, x_ctr1, y_ctr1;
    logic [19:0] pix_cnt1;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          last_fall = 0;
    logic [7:0]  img [0:9][0:9];
    res_t        exp_q[$];
    res_t        act_q[$];
    int          act_cyc_q[$];
    res_t        mon_r;
    res_t        a;
    res_t        e;
    int          a_cyc;

    object_bbox_tracker #(.IW(IW), .IH(IH), .MIN_PIX(64)) dut (
        .clk(clk), .rst(rst), .cap_vsync(cap_vsync), .pix_vld(pix_vld),
        .pix_data(pix_data), .thr(thr), .thr_inv(thr_inv),
        .bin_vld(bin_vld), .bin_data(bin_data), .res_vld(res_vld),
        .obj_found(obj_found), .x_min(x_min), .x_max(x_max),
        .y_min(y_min), .y_max(y_max), .x_ctr(x_ctr), .y_ctr(y_ctr),
        .pix_cnt(pix_cnt)
    );

    object_bbox_tracker #(.IW(IW), .IH(IH), .MIN_PIX(1)) dut1 (
        .clk(clk), .rst(rst), .cap_vsync(cap_vsync), .pix_vld(pix_vld),
        .pix_data(pix_data), .thr(thr), .thr_inv(thr_inv),
        .bin_vld(bin_vld1), .bin_data(bin_data1), .res_vld(res_vld1),
        .obj_found(obj_found1), .x_min(x_min1), .x_max(x_max1),
        .y_min(y_min1), .y_max(y_max1), .x_ctr(x_ctr1), .y_ctr(y_ctr1),
        .pix_cnt(pix_cnt1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result monitor: capture every published result with its cycle.
    always @(negedge clk) begin
        if (res_vld) begin
            mon_r = '{xmin: x_min, xmax: x_max, ymin: y_min, ymax: y_max,
                      xc: x_ctr, yc: y_ctr, cnt: pix_cnt,
                      found: obj_found, found1: obj_found1};
            act_q.push_back(mon_r);
            act_cyc_q.push_back(cyc);
        end
    end

    task automatic set_img(input logic [7:0] v);
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++)
                img[y][x] = v;
    endtask

    // Reference model: result expected from img for a frame of nl lines of
    // ll pixels, using the current thr/thr_inv.
    task automatic push_expect(input int nl, input int ll);
        res_t r;
        int xmn, xmx, ymn, ymx, cnt;
        xmn = IW - 1; xmx = 0; ymn = IH - 1; ymx = 0; cnt = 0;
        for (int y = 0; y < nl && y < IH; y++)
            for (int x = 0; x < ll && x < IW; x++)
                if (thr_inv ? (img[y][x] < thr) : (img[y][x] > thr)) begin
                    if (x < xmn) xmn = x;
                    if (x > xmx) xmx = x;
                    if (y < ymn) ymn = y;
                    if (y > ymx) ymx = y;
                    cnt++;
                end
        r = '0;
        if (cnt > 0) begin
            r.xmin = 10'(xmn); r.xmax = 10'(xmx);
            r.ymin = 10'(ymn); r.ymax = 10'(ymx);
            r.xc = 10'((xmn + xmx) / 2);
            r.yc = 10'((ymn + ymx) / 2);
            r.cnt = 20'(cnt);
            r.found = (cnt >= 64);
            r.found1 = 1'b1;
        end
        exp_q.push_back(r);
    endtask

    // Drives an optional vsync pulse then nl lines of ll pixels from img.
    // chain_vs raises vsync in the cycle after the last line's falling edge.
    task automatic send_frame(input int nl, input int ll, input bit do_vs,
                              input bit chain_vs);
        if (do_vs) begin
            @(posedge clk); #1 cap_vsync = 1'b1;
            repeat (3) @(posedge clk);
            #1 cap_vsync = 1'b0;
            repeat (2) @(posedge clk);
        end
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < ll; x++) begin
                @(posedge clk); #1 pix_vld = 1'b1; pix_data = img[y][x];
            end
            @(posedge clk); #1 pix_vld = 1'b0; pix_data = 8'd0;
            if (y == IH - 1) last_fall = cyc;
            if (chain_vs && y == nl - 1) begin
                @(posedge clk); #1 cap_vsync = 1'b1;
                repeat (3) @(posedge clk);
                #1 cap_vsync = 1'b0;
            end else begin
                repeat (3) @(posedge clk);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({res_vld, obj_found, x_min, x_max, y_min, y_max, x_ctr, y_ctr, pix_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_results: got x=%0d..%0d y=%0d..%0d cnt=%0d vld=%b found=%b, required all 0",
                     x_min, x_max, y_min, y_max, pix_cnt, res_vld, obj_found);
        end
        n_checks++;
        if ({bin_vld, bin_data} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_bin: got vld=%b data=%b, required 0 0", bin_vld, bin_data);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_single_pixel;
        thr = 8'd100; thr_inv = 1'b0;
        set_img(8'd0);
        img[2][3] = 8'd200;
        push_expect(IH, IW);
        send_frame(IH, IW, 1'b1, 1'b0);
        n_checks++;
        if (act_q.size() != 1) begin
            n_errors++;
            $display("FAIL single_pixel_pulses: got %0d, required 1", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL single_pixel_result: got %h, required %h", a, e);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if (x_min !== 10'd3 || y_max !== 10'd2 || pix_cnt !== 20'd1 || obj_found1 !== 1'b1) begin
            n_errors++;
            $display("FAIL output_hold: got x_min=%0d y_max=%0d cnt=%0d found1=%b, required 3 2 1 1",
                     x_min, y_max, pix_cnt, obj_found1);
        end
    endtask

    task automatic test_full_frame;
        bit exp_b;
        thr = 8'd0; thr_inv = 1'b0;
        set_img(8'd255);
        push_expect(IH, IW);
        send_frame(0, IW, 1'b1, 1'b0);
        for (int y = 0; y < IH; y++) begin
            for (int x = 0; x <= IW; x++) begin
                @(posedge clk); #1;
                exp_b = (x > 0);
                n_checks++;
                if (bin_vld !== exp_b || bin_data !== exp_b) begin
                    n_errors++;
                    $display("FAIL full_bin line %0d pos %0d: got vld=%b data=%b, required %b %b",
                             y, x, bin_vld, bin_data, exp_b, exp_b);
                end
                pix_vld = (x < IW);
                pix_data = (x < IW) ? img[y][x] : 8'd0;
            end
            repeat (3) @(posedge clk);
        end
        n_checks++;
        if (act_q.size() != 1) begin
            n_errors++;
            $display("FAIL full_pulses: got %0d, required 1", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL full_result: got %h, required %h", a, e);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
    endtask

    task automatic test_inversion;
        set_img(8'd50);
        thr = 8'd100;
        for (int inv = 1; inv >= 0; inv--) begin
            thr_inv = inv[0];
            push_expect(IH, IW);
            send_frame(IH, IW, 1'b1, 1'b0);
        end
        n_checks++;
        if (act_q.size() != 2) begin
            n_errors++;
            $display("FAIL inversion_pulses: got %0d, required 2", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL inversion_result: got %h, required %h", a, e);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
    endtask

    task automatic test_short_frame;
        thr = 8'd100; thr_inv = 1'b0;
        set_img(8'd0);
        img[0][7] = 8'd200;
        img[1][1] = 8'd200;
        send_frame(2, IW, 1'b1, 1'b0);
        img[1][1] = 8'd0;
        push_expect(IH, IW);
        send_frame(IH, IW, 1'b1, 1'b0);
        n_checks++;
        if (act_q.size() != 1) begin
            n_errors++;
            $display("FAIL short_frame_pulses: got %0d, required 1", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL short_frame_result: got %h, required %h", a, e);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
    endtask

    task automatic test_oversize;
        thr = 8'd100; thr_inv = 1'b0;
        set_img(8'd0);
        img[0][9] = 8'd200;
        img[1][8] = 8'd200;
        img[4][0] = 8'd200;
        img[5][5] = 8'd200;
        img[1][1] = 8'd200;
        img[3][6] = 8'd200;
        push_expect(6, 10);
        send_frame(6, 10, 1'b1, 1'b0);
        n_checks++;
        if (act_q.size() != 1) begin
            n_errors++;
            $display("FAIL oversize_pulses: got %0d, required 1", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL oversize_result: got %h, required %h", a, e);
            end
            n_checks++;
            if (a_cyc != last_fall + 2) begin
                n_errors++;
                $display("FAIL result_latency: got cycle %0d, required %0d", a_cyc, last_fall + 2);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
    endtask

    task automatic test_back_to_back;
        thr = 8'd100; thr_inv = 1'b0;
        set_img(8'd0);
        img[0][0] = 8'd200;
        img[1][5] = 8'd200;
        push_expect(IH, IW);
        send_frame(IH, IW, 1'b1, 1'b1);
        set_img(8'd0);
        img[3][7] = 8'd200;
        push_expect(IH, IW);
        send_frame(IH, IW, 1'b0, 1'b0);
        n_checks++;
        if (act_q.size() != 2) begin
            n_errors++;
            $display("FAIL back_to_back_pulses: got %0d, required 2", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL back_to_back_result: got %h, required %h", a, e);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
    endtask

    task automatic test_reset_mid_frame;
        thr = 8'd100; thr_inv = 1'b0;
        set_img(8'd0);
        img[1][2] = 8'd200;
        send_frame(2, IW, 1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({x_max, y_max, pix_cnt, obj_found1, res_vld} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_outputs: got x_max=%0d y_max=%0d cnt=%0d found1=%b vld=%b, required all 0",
                     x_max, y_max, pix_cnt, obj_found1, res_vld);
        end
        rst = 1'b0;
        send_frame(IH, IW, 1'b0, 1'b0);
        n_checks++;
        if (act_q.size() != 0) begin
            n_errors++;
            $display("FAIL reset_mid_no_result: got %0d pulses, required 0", act_q.size());
        end
        act_q.delete(); act_cyc_q.delete();
        push_expect(IH, IW);
        send_frame(IH, IW, 1'b1, 1'b0);
        n_checks++;
        if (act_q.size() != 1) begin
            n_errors++;
            $display("FAIL reset_recovery_pulses: got %0d, required 1", act_q.size());
        end
        while (act_q.size() > 0 && exp_q.size() > 0) begin
            a = act_q.pop_front(); e = exp_q.pop_front(); a_cyc = act_cyc_q.pop_front();
            n_checks++;
            if (a !== e) begin
                n_errors++;
                $display("FAIL reset_recovery_result: got %h, required %h", a, e);
            end
        end
        exp_q.delete(); act_q.delete(); act_cyc_q.delete();
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_full_frame();
        test_inversion();
        test_short_frame();
        test_oversize();
        test_back_to_back();
        test_reset_mid_frame();
        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
